// File: rtl/i2c_rx_capture_if.sv
// i2c_rx_capture_if: controller-side inputs and APB-side FIFO outputs of the I2C RX capture stage
interface i2c_rx_capture_if #(parameter int ADDR_W = 3);
  logic scl_in;
  logic sda_in;
  logic rx_enable;
  logic rd_en;
  logic clr_overflow;
  logic [7:0] rd_data;
  logic rx_empty;
  logic rx_full;
  logic [ADDR_W:0] rx_count;
  logic byte_done;
  logic overflow;
  modport slave(
    input scl_in, sda_in, rx_enable, rd_en, clr_overflow,
    output rd_data, rx_empty, rx_full, rx_count, byte_done, overflow
  );
  modport master(
    output scl_in, sda_in, rx_enable, rd_en, clr_overflow,
    input rd_data, rx_empty, rx_full, rx_count, byte_done, overflow
  );
endinterface

// File: rtl/i2c_rx_capture.sv
// i2c_rx_capture: samples SDA on SCL rises into bytes, MSB first, and queues them in a FWFT RX FIFO
module i2c_rx_capture #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic               i2c_core_clk,
  input  logic               rst,
  i2c_rx_capture_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;
  state_t r_state, w_state_n;
  logic r_scl_s1, r_scl_s2, r_scl_prev, r_sda_s1, r_sda_s2;
  logic [7:0] r_shreg;
  logic [2:0] r_bitcnt;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0] r_count;
  logic r_overflow;
  logic [7:0] r_mem [DEPTH];
  logic w_rise, w_shift, w_push, w_pop, w_wr;
  assign w_rise  = r_scl_s2 & ~r_scl_prev;
  assign w_shift = bus.rx_enable & w_rise & (r_state != PUSH);
  assign w_push  = (r_state == PUSH);
  assign w_pop   = bus.rd_en & (r_count != '0);
  // a full FIFO still accepts the byte when the same cycle frees a slot
  assign w_wr    = w_push & (~bus.rx_full | w_pop);
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    w_state_n = bus.rx_enable ? SHIFT : IDLE;
      SHIFT:   w_state_n = !bus.rx_enable ? IDLE : (w_rise && r_bitcnt == 3'd7) ? PUSH : SHIFT;
      PUSH:    w_state_n = bus.rx_enable ? SHIFT : IDLE;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge i2c_core_clk or posedge rst) begin
    if (rst) begin
      {r_scl_s1, r_scl_s2, r_scl_prev, r_sda_s1, r_sda_s2} <= '1;
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_scl_s1   <= bus.scl_in;
      r_scl_s2   <= r_scl_s1;
      r_scl_prev <= r_scl_s2;
      r_sda_s1   <= bus.sda_in;
      r_sda_s2   <= r_sda_s1;
      r_state    <= w_state_n;
      r_shreg    <= w_shift ? {r_shreg[6:0], r_sda_s2} : r_shreg;
      r_bitcnt   <= (!bus.rx_enable || w_push) ? 3'd0 : w_shift ? r_bitcnt + 3'd1 : r_bitcnt;
      r_wr_ptr   <= r_wr_ptr + ADDR_W'(w_wr);
      r_rd_ptr   <= r_rd_ptr + ADDR_W'(w_pop);
      r_count    <= r_count + (ADDR_W+1)'(w_wr) - (ADDR_W+1)'(w_pop);
      r_overflow <= (w_push & ~w_wr) ? 1'b1 : bus.clr_overflow ? 1'b0 : r_overflow;
    end
  end
  always_ff @(posedge i2c_core_clk)
    if (w_wr) r_mem[r_wr_ptr] <= r_shreg;
  assign bus.rd_data   = r_mem[r_rd_ptr];
  assign bus.rx_empty  = (r_count == '0);
  assign bus.rx_full   = (r_count == (ADDR_W+1)'(DEPTH));
  assign bus.rx_count  = r_count;
  assign bus.byte_done = w_push;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_i2c_rx_capture.sv
// tb_i2c_rx_capture: directed checks of byte capture, FIFO ordering, abort, overflow and reset
module tb_i2c_rx_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int done0;
  i2c_rx_capture_if #(.ADDR_W(3)) bus();
  i2c_rx_capture #(.DEPTH(8), .ADDR_W(3)) dut (
    .i2c_core_clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.byte_done) n_done++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pop();
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
  endtask
  task automatic send_bits(input logic [7:0] d, input int n, input bit pop_on_push);
    for (int b = 0; b < n; b++) begin
      bus.sda_in = d[7-b];
      bus.scl_in = 1'b0;
      tick(4);
      bus.scl_in = 1'b1;
      for (int t = 0; t < 4; t++) begin
        bus.rd_en = pop_on_push & bus.byte_done;
        tick(1);
      end
      bus.rd_en = 1'b0;
    end
    bus.scl_in = 1'b0;
    tick(4);
  endtask
  initial begin
    bus.scl_in = 1'b0;
    bus.sda_in = 1'b0;
    bus.rx_enable = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr_overflow = 1'b0;
    tick(3);
    chk("rst_empty", bus.rx_empty, 1);
    chk("rst_full", bus.rx_full, 0);
    chk("rst_count", bus.rx_count, 0);
    chk("rst_done", bus.byte_done, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst = 1'b0;
    tick(3);
    // 1: single byte
    bus.rx_enable = 1'b1;
    done0 = n_done;
    send_bits(8'hA5, 8, 0);
    chk("t1_done", n_done - done0, 1);
    chk("t1_data", bus.rd_data, 8'hA5);
    chk("t1_count", bus.rx_count, 1);
    chk("t1_empty", bus.rx_empty, 0);
    pop();
    chk("t1_popped", bus.rx_count, 0);
    // 2: back-to-back bytes and ordering
    send_bits(8'h3C, 8, 0);
    send_bits(8'hC3, 8, 0);
    chk("t2_count2", bus.rx_count, 2);
    chk("t2_head0", bus.rd_data, 8'h3C);
    pop();
    chk("t2_count1", bus.rx_count, 1);
    chk("t2_head1", bus.rd_data, 8'hC3);
    pop();
    chk("t2_count0", bus.rx_count, 0);
    chk("t2_empty", bus.rx_empty, 1);
    pop();
    chk("t2_pop_empty", bus.rx_count, 0);
    // 3: partial byte discarded on rx_enable drop
    send_bits(8'hFF, 5, 0);
    bus.rx_enable = 1'b0;
    tick(3);
    bus.rx_enable = 1'b1;
    send_bits(8'h0F, 8, 0);
    chk("t3_count", bus.rx_count, 1);
    chk("t3_data", bus.rd_data, 8'h0F);
    pop();
    // 4: fill, overflow, clear
    for (int i = 0; i < 8; i++) send_bits(8'(i), 8, 0);
    chk("t4_full", bus.rx_full, 1);
    chk("t4_count8", bus.rx_count, 8);
    chk("t4_ovf0", bus.overflow, 0);
    done0 = n_done;
    send_bits(8'hFF, 8, 0);
    chk("t4_done", n_done - done0, 1);
    chk("t4_ovf1", bus.overflow, 1);
    chk("t4_count", bus.rx_count, 8);
    chk("t4_head", bus.rd_data, 8'h00);
    bus.clr_overflow = 1'b1;
    tick(1);
    bus.clr_overflow = 1'b0;
    chk("t4_clr", bus.overflow, 0);
    // 5: pop in the PUSH cycle while full
    send_bits(8'h55, 8, 1);
    chk("t5_ovf", bus.overflow, 0);
    chk("t5_count", bus.rx_count, 8);
    chk("t5_head", bus.rd_data, 8'h01);
    for (int i = 0; i < 7; i++) pop();
    chk("t5_last", bus.rd_data, 8'h55);
    pop();
    chk("t5_drained", bus.rx_empty, 1);
    // 6: reset mid-byte
    send_bits(8'h11, 8, 0);
    send_bits(8'h22, 8, 0);
    send_bits(8'h33, 8, 0);
    chk("t6_count3", bus.rx_count, 3);
    send_bits(8'hF0, 4, 0);
    rst = 1'b1;
    #1;
    chk("t6_rcount", bus.rx_count, 0);
    chk("t6_rempty", bus.rx_empty, 1);
    chk("t6_rovf", bus.overflow, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    send_bits(8'h81, 8, 0);
    chk("t6_count", bus.rx_count, 1);
    chk("t6_data", bus.rd_data, 8'h81);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
